cafeteira_uc: RTL and testbench
===============================

CAFETEIRA_UC -- requirements
Module: cafeteira_uc

Interface
REQ-001 Parameter MAX_TENTATIVAS, default 3: number of cup measurements tried before the order aborts.
REQ-002 clock  in  1  single system clock; all state updates occur on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 rearma  in  1  operator re-arm; leaves ERRO.
REQ-005 pronto_serial  in  1  order (modo) received from ESP.
REQ-006 pronto_sensor_xicara  in  1  cup measurement complete.
REQ-007 timeout_xicara  in  1  cup sensor echo timeout.
REQ-008 tem_xicara  in  1  cup present; valid when pronto_sensor_xicara=1.
REQ-009 fim_bomba  in  1  pump dose complete.
REQ-010 fim_ebulidor  in  1  target temperature reached.
REQ-011 timeout_ebulidor  in  1  boiler heating timeout.
REQ-012 fim_valvula  in  1  valve dispense complete.
REQ-013 fim_contagem  in  1  pump-to-boiler interference wait elapsed.
REQ-014 fim_espera_fim  in  1  final drip wait elapsed.
REQ-015 zera_serial, zera_sensor_xicara, zera_bomba, zera_ebulidor, zera_valvula  out  1 each  synchronous clears to datapath blocks.
REQ-016 verifica_xicara  out  1  one-cycle measurement start pulse.
REQ-017 liga_bomba  out  1  pump enable.
REQ-018 liga_ebulidor  out  1  boiler enable.
REQ-019 liga_valvula  out  1  valve enable.
REQ-020 conta_interferencia  out  1  interference counter enable.
REQ-021 conta_fim  out  1  final-wait counter enable.
REQ-022 pronto  out  1  one-cycle "coffee served" pulse.
REQ-023 erro  out  1  fault indication, level.
REQ-024 db_estado  out  4  current state code.

Function
REQ-025 Moore FSM; all outputs decoded from the state register only; all outputs 0 except as listed per state.
REQ-026 States/codes: INICIAL 0, ESPERA_PEDIDO 1, MEDE_XICARA 2, ESPERA_XICARA 3, BOMBA 4, INTERFERENCIA 5, EBULIDOR 6, VALVULA 7, ESPERA_FIM 8, FIM 9, ERRO F; codes A-E unused and go to INICIAL next cycle.
REQ-027 INICIAL: all five zera_* = 1, tentativas cleared to 0; next ESPERA_PEDIDO unconditionally.
REQ-028 ESPERA_PEDIDO: hold until pronto_serial=1, then MEDE_XICARA.
REQ-029 MEDE_XICARA: verifica_xicara=1 for exactly one cycle; next ESPERA_XICARA.
REQ-030 ESPERA_XICARA: pronto_sensor_xicara=1 and tem_xicara=1 -> BOMBA; pronto_sensor_xicara=1 with tem_xicara=0, or timeout_xicara=1, counts a failure; both pronto and timeout in same cycle count as one failure unless pronto with tem_xicara=1 (success wins).
REQ-031 On failure: tentativas+1 (2-bit saturating); if the new value equals MAX_TENTATIVAS -> ERRO, else -> MEDE_XICARA.
REQ-032 BOMBA: liga_bomba=1 until fim_bomba=1, then INTERFERENCIA.
REQ-033 INTERFERENCIA: conta_interferencia=1 until fim_contagem=1, then EBULIDOR.
REQ-034 EBULIDOR: liga_ebulidor=1; fim_ebulidor=1 -> VALVULA; timeout_ebulidor=1 -> ERRO; both together -> VALVULA.
REQ-035 VALVULA: liga_valvula=1 until fim_valvula=1, then ESPERA_FIM.
REQ-036 ESPERA_FIM: conta_fim=1 until fim_espera_fim=1, then FIM.
REQ-037 FIM: pronto=1 for one cycle; next INICIAL.
REQ-038 ERRO: erro=1, all liga_*/conta_* = 0; rearma=1 -> INICIAL; otherwise hold.
REQ-039 At most one of liga_bomba, liga_ebulidor, liga_valvula is 1 in any cycle.

Reset
REQ-040 reset=0 forces INICIAL immediately, independent of clock; while reset=0, all zera_*=1, all other outputs 0, db_estado=0.
REQ-041 Reset asserted mid-operation (any state) removes all actuator enables asynchronously; after release the FSM proceeds INICIAL -> ESPERA_PEDIDO.

Verification
REQ-042 Happy path: pronto_serial, cup present, each fim_* after 5 cycles -> db_estado 0,1,2,3,4,5,6,7,8,9,0; pronto high exactly 1 cycle.
REQ-043 Cup absent twice, then present -> verifica_xicara pulses 3 times, reaches BOMBA; erro stays 0.
REQ-044 timeout_xicara 3 consecutive times -> ERRO (db_estado=F), erro=1, liga_bomba never 1; rearma -> INICIAL.
REQ-045 timeout_ebulidor in EBULIDOR -> ERRO next cycle, liga_ebulidor=0; fim_ebulidor+timeout same cycle -> VALVULA.
REQ-046 reset=0 during BOMBA -> liga_bomba falls before next clock edge, db_estado=0, zera_bomba=1.
REQ-047 Force unused code 0xC via bench -> INICIAL next cycle; no actuator enabled.

Source files
------------

// File: rtl/cafeteira_uc.sv
// cafeteira_uc: control unit for the coffee machine.
// Sequences cup check, pump, boiler, valve and final drip.
module cafeteira_uc #(
  parameter int MAX_TENTATIVAS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rearma,
  input  logic       pronto_serial,
  input  logic       pronto_sensor_xicara,
  input  logic       timeout_xicara,
  input  logic       tem_xicara,
  input  logic       fim_bomba,
  input  logic       fim_ebulidor,
  input  logic       timeout_ebulidor,
  input  logic       fim_valvula,
  input  logic       fim_contagem,
  input  logic       fim_espera_fim,
  output logic       zera_serial,
  output logic       zera_sensor_xicara,
  output logic       zera_bomba,
  output logic       zera_ebulidor,
  output logic       zera_valvula,
  output logic       verifica_xicara,
  output logic       liga_bomba,
  output logic       liga_ebulidor,
  output logic       liga_valvula,
  output logic       conta_interferencia,
  output logic       conta_fim,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    ESPERA_PEDIDO = 4'h1,
    MEDE_XICARA   = 4'h2,
    ESPERA_XICARA = 4'h3,
    BOMBA         = 4'h4,
    INTERFERENCIA = 4'h5,
    EBULIDOR      = 4'h6,
    VALVULA       = 4'h7,
    ESPERA_FIM    = 4'h8,
    FIM           = 4'h9,
    ERRO          = 4'hF
  } estado_t;

  logic [3:0] estado;
  estado_t    prox;
  logic [1:0] tentativas;
  logic [1:0] tent_inc;
  logic       xic_ok;
  logic       xic_falha;

  assign xic_ok    = pronto_sensor_xicara & tem_xicara;
  assign xic_falha = (estado == ESPERA_XICARA) & ~xic_ok &
                     (pronto_sensor_xicara | timeout_xicara);
  assign tent_inc  = (tentativas == 2'b11) ? 2'b11 : tentativas + 2'd1;

  always_comb begin
    prox = INICIAL;
    case (estado)
      INICIAL:       prox = ESPERA_PEDIDO;
      ESPERA_PEDIDO: prox = pronto_serial ? MEDE_XICARA : ESPERA_PEDIDO;
      MEDE_XICARA:   prox = ESPERA_XICARA;
      ESPERA_XICARA: begin
        if (xic_ok)
          prox = BOMBA;
        else if (pronto_sensor_xicara | timeout_xicara)
          prox = (int'(tent_inc) == MAX_TENTATIVAS) ? ERRO : MEDE_XICARA;
        else
          prox = ESPERA_XICARA;
      end
      BOMBA:         prox = fim_bomba ? INTERFERENCIA : BOMBA;
      INTERFERENCIA: prox = fim_contagem ? EBULIDOR : INTERFERENCIA;
      EBULIDOR: begin
        // reaching temperature wins over a coincident timeout
        if (fim_ebulidor)
          prox = VALVULA;
        else if (timeout_ebulidor)
          prox = ERRO;
        else
          prox = EBULIDOR;
      end
      VALVULA:       prox = fim_valvula ? ESPERA_FIM : VALVULA;
      ESPERA_FIM:    prox = fim_espera_fim ? FIM : ESPERA_FIM;
      FIM:           prox = INICIAL;
      ERRO:          prox = rearma ? INICIAL : ERRO;
      default:       prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado     <= INICIAL;
      tentativas <= 2'b00;
    end else begin
      estado <= prox;
      if (estado == INICIAL)
        tentativas <= 2'b00;
      else if (xic_falha)
        tentativas <= tent_inc;
    end
  end

  // pure decode of the state flop, so reset clears actuators at once
  assign zera_serial         = (estado == INICIAL);
  assign zera_sensor_xicara  = (estado == INICIAL);
  assign zera_bomba          = (estado == INICIAL);
  assign zera_ebulidor       = (estado == INICIAL);
  assign zera_valvula        = (estado == INICIAL);
  assign verifica_xicara     = (estado == MEDE_XICARA);
  assign liga_bomba          = (estado == BOMBA);
  assign liga_ebulidor       = (estado == EBULIDOR);
  assign liga_valvula        = (estado == VALVULA);
  assign conta_interferencia = (estado == INTERFERENCIA);
  assign conta_fim           = (estado == ESPERA_FIM);
  assign pronto              = (estado == FIM);
  assign erro                = (estado == ERRO);
  assign db_estado           = estado;

endmodule

// File: tb/tb_cafeteira_uc.sv
// tb_cafeteira_uc: scoreboard bench for cafeteira_uc.
// Stimulus queues expected outputs per cycle; a monitor compares them.
module tb_cafeteira_uc;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [10:0] ins = '0;

  logic zera_serial, zera_sensor_xicara, zera_bomba;
  logic zera_ebulidor, zera_valvula, verifica_xicara;
  logic liga_bomba, liga_ebulidor, liga_valvula;
  logic conta_interferencia, conta_fim, pronto, erro;
  logic [3:0] db_estado;

  localparam logic [10:0] RA  = 11'h001;
  localparam logic [10:0] PS  = 11'h002;
  localparam logic [10:0] PSX = 11'h004;
  localparam logic [10:0] TX  = 11'h008;
  localparam logic [10:0] TEM = 11'h010;
  localparam logic [10:0] FB  = 11'h020;
  localparam logic [10:0] FE  = 11'h040;
  localparam logic [10:0] TE  = 11'h080;
  localparam logic [10:0] FV  = 11'h100;
  localparam logic [10:0] FC  = 11'h200;
  localparam logic [10:0] FEF = 11'h400;

  cafeteira_uc #(.MAX_TENTATIVAS(3)) dut (
    .clock               (clock),
    .reset               (reset),
    .rearma              (ins[0]),
    .pronto_serial       (ins[1]),
    .pronto_sensor_xicara(ins[2]),
    .timeout_xicara      (ins[3]),
    .tem_xicara          (ins[4]),
    .fim_bomba           (ins[5]),
    .fim_ebulidor        (ins[6]),
    .timeout_ebulidor    (ins[7]),
    .fim_valvula         (ins[8]),
    .fim_contagem        (ins[9]),
    .fim_espera_fim      (ins[10]),
    .zera_serial         (zera_serial),
    .zera_sensor_xicara  (zera_sensor_xicara),
    .zera_bomba          (zera_bomba),
    .zera_ebulidor       (zera_ebulidor),
    .zera_valvula        (zera_valvula),
    .verifica_xicara     (verifica_xicara),
    .liga_bomba          (liga_bomba),
    .liga_ebulidor       (liga_ebulidor),
    .liga_valvula        (liga_valvula),
    .conta_interferencia (conta_interferencia),
    .conta_fim           (conta_fim),
    .pronto              (pronto),
    .erro                (erro),
    .db_estado           (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [16:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;

  always @(negedge clock) cyc <= cyc + 1;

  function automatic logic [16:0] ev(input logic [3:0] s);
    logic [12:0] f;
    f = '0;
    case (s)
      4'h0: f[12:8] = 5'b11111;
      4'h2: f[7] = 1'b1;
      4'h4: f[6] = 1'b1;
      4'h6: f[5] = 1'b1;
      4'h7: f[4] = 1'b1;
      4'h5: f[3] = 1'b1;
      4'h8: f[2] = 1'b1;
      4'h9: f[1] = 1'b1;
      4'hF: f[0] = 1'b1;
      default: f = '0;
    endcase
    return {s, f};
  endfunction

  logic [16:0] got;
  assign got = {db_estado, zera_serial, zera_sensor_xicara,
                zera_bomba, zera_ebulidor, zera_valvula,
                verifica_xicara, liga_bomba, liga_ebulidor,
                liga_valvula, conta_interferencia, conta_fim,
                pronto, erro};

  always @(negedge clock) begin : monitor
    exp_t e;
    if (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_vec++;
      if (e.cyc != cyc || got !== e.v) begin
        n_bad++;
        $display("FAIL %s cyc=%0d: got %h/%b, want %h/%b",
                 e.nm, cyc, got[16:13], got[12:0],
                 e.v[16:13], e.v[12:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic chk(input logic [3:0] st, input string nm);
    exp_t e;
    e.cyc = cyc;
    e.v   = ev(st);
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic leave(input logic [3:0] st, input int n,
                       input logic [10:0] m, input string nm);
    for (int i = 0; i < n - 1; i++) begin
      chk(st, nm);
      tick();
    end
    ins = m;
    chk(st, nm);
    tick();
    ins = '0;
  endtask

  task automatic to_bomba(input string nm);
    leave(4'h1, 1, PS, nm);
    leave(4'h2, 1, '0, nm);
    leave(4'h3, 1, PSX | TEM, nm);
  endtask

  initial begin
    tick();
    chk(4'h0, "reset");
    tick();
    chk(4'h0, "reset_hold");
    reset = 1'b1;
    tick();

    // happy path with 5-cycle waits on every completion input
    leave(4'h1, 3, PS, "happy");
    leave(4'h2, 1, '0, "happy");
    leave(4'h3, 2, PSX | TEM, "happy");
    leave(4'h4, 5, FB, "happy");
    leave(4'h5, 5, FC, "happy");
    leave(4'h6, 5, FE, "happy");
    leave(4'h7, 5, FV, "happy");
    leave(4'h8, 5, FEF, "happy");
    leave(4'h9, 1, '0, "happy_pronto");
    leave(4'h0, 1, '0, "happy_end");

    // cup absent twice, then present
    leave(4'h1, 1, PS, "retry");
    leave(4'h2, 1, '0, "retry");
    leave(4'h3, 1, PSX, "retry_absent1");
    leave(4'h2, 1, '0, "retry");
    leave(4'h3, 2, PSX, "retry_absent2");
    leave(4'h2, 1, '0, "retry");
    leave(4'h3, 1, PSX | TEM, "retry_present");
    leave(4'h4, 2, '0, "retry_bomba");

    // async reset while pumping
    #1 reset = 1'b0;
    chk(4'h0, "rst_in_bomba");
    tick();
    chk(4'h0, "rst_held");
    reset = 1'b1;
    tick();
    leave(4'h1, 1, '0, "after_rst");

    // three cup timeouts abort; last one coincides with absent reading
    leave(4'h1, 1, PS, "tmo");
    leave(4'h2, 1, '0, "tmo");
    leave(4'h3, 1, TX, "tmo1");
    leave(4'h2, 1, '0, "tmo");
    leave(4'h3, 3, TX, "tmo2");
    leave(4'h2, 1, '0, "tmo");
    leave(4'h3, 1, TX | PSX, "tmo3");
    leave(4'hF, 3, RA, "erro_rearma");
    leave(4'h0, 1, '0, "post_erro");

    // success wins over a coincident cup timeout
    leave(4'h1, 1, PS, "tx_ok");
    leave(4'h2, 1, '0, "tx_ok");
    leave(4'h3, 1, TX | PSX | TEM, "tx_ok");
    leave(4'h4, 1, FB, "eb_tmo");
    leave(4'h5, 1, FC, "eb_tmo");
    leave(4'h6, 2, TE, "eb_tmo");
    leave(4'hF, 1, RA, "eb_erro");
    leave(4'h0, 1, '0, "eb_erro");

    // boiler done and timeout together proceeds to the valve
    to_bomba("eb_both");
    leave(4'h4, 1, FB, "eb_both");
    leave(4'h5, 1, FC, "eb_both");
    leave(4'h6, 1, FE | TE, "eb_both");
    leave(4'h7, 1, FV, "eb_both");
    leave(4'h8, 1, FEF, "eb_both");
    leave(4'h9, 1, '0, "eb_both");
    leave(4'h0, 1, '0, "eb_both");

    // unused code falls back to INICIAL
    force dut.estado = 4'hC;
    chk(4'hC, "unused_c");
    @(negedge clock);
    #1 release dut.estado;
    tick();
    leave(4'h0, 1, '0, "unused_next");
    chk(4'h1, "final");

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clock);
    #1;
    if (q.size() > 0) begin
      $display("FAIL drain: %0d pending, want 0", q.size());
      n_bad += q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
